// File: rtl/bram_rmw_controller.sv
// Requester-side controller for a word-wide block RAM with a 1-cycle registered read.
// Sub-word stores are done as read-modify-write; one request in flight, one response each.
//
// state | meaning
// IDLE  | ready for a request; RAM read address follows req_address
// DATA  | old word on ram_read_data; merge and commit a write, capture the response
// RESP  | response held until the consumer takes it
module bram_rmw_controller #(
   parameter int SIZE  = 1024,
   parameter int WIDTH = 32,
   localparam int AW   = $clog2(SIZE),
   localparam int NB   = WIDTH / 8,
   localparam int LW   = $clog2(NB),
   localparam int WAW  = AW - LW
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_write,
   input  logic [AW-1:0]    req_address,
   input  logic [WIDTH-1:0] req_wdata,
   input  logic [NB-1:0]    req_wstrb,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [WIDTH-1:0] resp_rdata,
   output logic             ram_write_en,
   output logic [WAW-1:0]   ram_write_address,
   output logic [WIDTH-1:0] ram_write_data,
   output logic [WAW-1:0]   ram_read_address,
   input  logic [WIDTH-1:0] ram_read_data
);

   typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

   state_t           state_q, state_d;
   logic             write_q, write_d;
   logic [WAW-1:0]   addr_q, addr_d;
   logic [WIDTH-1:0] wdata_q, wdata_d;
   logic [NB-1:0]    wstrb_q, wstrb_d;
   logic             resp_valid_q, resp_valid_d;
   logic [WIDTH-1:0] resp_rdata_q, resp_rdata_d;
   logic [WIDTH-1:0] merged;
   logic [WAW-1:0]   req_word;

   assign req_word = req_address[AW-1:LW];

   // Byte lanes below the word index select nothing in a word-wide RAM.
   if (LW > 0) begin : g_lsb
      logic unused_lsb;
      assign unused_lsb = ^req_address[LW-1:0];
   end

   // Parameter sanity: whole bytes per word and a whole number of words.
   assert property (@(posedge clk) (WIDTH >= 8) && (WIDTH % 8 == 0) && (SIZE % NB == 0));

   // State and latched request/response registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         write_q      <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         write_q      <= write_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         wstrb_q      <= wstrb_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

   // Lane merge of the latched store data over the old word.
   always_comb begin
      merged = ram_read_data;
      for (int i = 0; i < NB; i++) begin
         if (wstrb_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
      end
   end

   // Next-state and register updates.
   always_comb begin
      state_d      = state_q;
      write_d      = write_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      wstrb_d      = wstrb_q;
      resp_valid_d = resp_valid_q;
      resp_rdata_d = resp_rdata_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               write_d = req_write;
               addr_d  = req_word;
               wdata_d = req_wdata;
               wstrb_d = req_wstrb;
               state_d = DATA;
            end
         end
         DATA: begin
            resp_rdata_d = ram_read_data;
            resp_valid_d = 1'b1;
            state_d      = RESP;
         end
         RESP: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs; ready and write enable are gated by reset so they drop immediately.
   always_comb begin
      req_ready         = (state_q == IDLE) && !reset;
      ram_read_address  = (state_q == IDLE) ? req_word : addr_q;
      ram_write_en      = (state_q == DATA) && write_q && (|wstrb_q) && !reset;
      ram_write_address = addr_q;
      ram_write_data    = merged;
      resp_valid        = resp_valid_q;
      resp_rdata        = resp_rdata_q;
   end

endmodule

// File: tb/tb_bram_rmw_controller.sv
// Directed bench for bram_rmw_controller with a behavioural 1-cycle block RAM.
module tb_bram_rmw_controller;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [9:0]  req_address = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_wstrb = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_rdata;
   logic        ram_write_en;
   logic [7:0]  ram_write_address;
   logic [31:0] ram_write_data;
   logic [7:0]  ram_read_address;
   logic [31:0] ram_read_data;

   logic [31:0] mem [256];
   int          cyc = 0;
   int          wr_count = 0;
   int          acc_count = 0;
   logic [7:0]  last_wa = '0;
   int          tests_run = 0;
   int          tests_failed = 0;

   bram_rmw_controller #(.SIZE(1024), .WIDTH(32)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_address(req_address), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
      .ram_write_en(ram_write_en), .ram_write_address(ram_write_address),
      .ram_write_data(ram_write_data), .ram_read_address(ram_read_address),
      .ram_read_data(ram_read_data)
   );

   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
   end

   // Block RAM model plus activity monitors.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (ram_write_en) begin
         mem[ram_write_address] <= ram_write_data;
         wr_count <= wr_count + 1;
         last_wa <= ram_write_address;
      end
      ram_read_data <= mem[ram_read_address];
      if (req_valid && req_ready) acc_count <= acc_count + 1;
   end

   // Issue one request with resp_ready high; returns data, accept cycle and latency.
   task automatic do_req(input bit w, input logic [9:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rd,
                         output int acc, output int lat);
      int n;
      @(negedge clk);
      req_write = w; req_address = a; req_wdata = d; req_wstrb = s;
      req_valid = 1'b1; resp_ready = 1'b1;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      acc = cyc;
      req_valid = 1'b0;
      lat = -1;
      rd = 'x;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (resp_valid) begin
            rd = resp_rdata;
            lat = cyc - acc;
            break;
         end
      end
      if (lat >= 0) @(posedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #12;
      tests_run++;
      if (req_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_req_ready got %0b want 0", req_ready); end
      tests_run++;
      if (resp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_resp_valid got %0b want 0", resp_valid); end
      tests_run++;
      if (resp_rdata !== 32'h0) begin tests_failed++; $display("FAIL reset_resp_rdata got %h want 0", resp_rdata); end
      tests_run++;
      if (ram_write_en !== 1'b0) begin tests_failed++; $display("FAIL reset_ram_we got %0b want 0", ram_write_en); end
      @(negedge clk);
      reset = 1'b0;
      #1;
      tests_run++;
      if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_release_ready got %0b want 1", req_ready); end
   endtask

   task automatic test_full_write_read();
      logic [31:0] rd;
      int acc, lat;
      do_req(1'b1, 10'h040, 32'hDEADBEEF, 4'b1111, rd, acc, lat);
      tests_run++;
      if (rd !== 32'h0) begin tests_failed++; $display("FAIL wr_full_old got %h want 00000000", rd); end
      tests_run++;
      if (last_wa !== 8'h10) begin tests_failed++; $display("FAIL wr_full_addr got %h want 10", last_wa); end
      tests_run++;
      if (mem[16] !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL wr_full_ram got %h want deadbeef", mem[16]); end
      do_req(1'b0, 10'h040, 32'h0, 4'b0000, rd, acc, lat);
      tests_run++;
      if (rd !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL rd_full got %h want deadbeef", rd); end
      // Accept edge plus the DATA edge: resp_valid is seen one cycle after the accept cycle.
      tests_run++;
      if (lat !== 1) begin tests_failed++; $display("FAIL rd_latency got %0d want 1", lat); end
   endtask

   task automatic test_partial_write();
      logic [31:0] rd;
      int acc, lat;
      do_req(1'b1, 10'h041, 32'h0000AA00, 4'b0010, rd, acc, lat);
      tests_run++;
      if (rd !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL wr_part_old got %h want deadbeef", rd); end
      do_req(1'b0, 10'h040, 32'h0, 4'b0000, rd, acc, lat);
      tests_run++;
      if (rd !== 32'hDEADAAEF) begin tests_failed++; $display("FAIL rd_merged got %h want deadaaef", rd); end
   endtask

   task automatic test_resp_stall();
      int acc0;
      int n;
      @(negedge clk);
      req_write = 1'b0; req_address = 10'h040; req_wstrb = 4'b0000;
      req_valid = 1'b1; resp_ready = 1'b0;
      n = 0;
      while (!resp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      req_address = 10'h080;
      acc0 = acc_count;
      for (int k = 0; k < 5; k++) begin
         tests_run++;
         if (resp_valid !== 1'b1) begin tests_failed++; $display("FAIL stall_valid[%0d] got %0b want 1", k, resp_valid); end
         tests_run++;
         if (resp_rdata !== 32'hDEADAAEF) begin tests_failed++; $display("FAIL stall_data[%0d] got %h want deadaaef", k, resp_rdata); end
         tests_run++;
         if (req_ready !== 1'b0) begin tests_failed++; $display("FAIL stall_ready[%0d] got %0b want 0", k, req_ready); end
         @(negedge clk);
      end
      tests_run++;
      if (acc_count !== acc0) begin tests_failed++; $display("FAIL stall_accepts got %0d want %0d", acc_count, acc0); end
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      tests_run++;
      if (resp_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_release got %0b want 0", resp_valid); end
   endtask

   task automatic test_zero_strobe();
      logic [31:0] rd;
      int acc, lat, w0;
      w0 = wr_count;
      do_req(1'b1, 10'h040, 32'hFFFFFFFF, 4'b0000, rd, acc, lat);
      tests_run++;
      if (lat !== 1) begin tests_failed++; $display("FAIL zstrb_resp got latency %0d want 1", lat); end
      tests_run++;
      if (wr_count !== w0) begin tests_failed++; $display("FAIL zstrb_writes got %0d want %0d", wr_count, w0); end
      do_req(1'b0, 10'h040, 32'h0, 4'b0000, rd, acc, lat);
      tests_run++;
      if (rd !== 32'hDEADAAEF) begin tests_failed++; $display("FAIL zstrb_word got %h want deadaaef", rd); end
   endtask

   task automatic test_reset_mid_op();
      logic [31:0] rd;
      int acc, lat, w0;
      do_req(1'b1, 10'h044, 32'hCAFEF00D, 4'b1111, rd, acc, lat);
      w0 = wr_count;
      @(negedge clk);
      req_write = 1'b1; req_address = 10'h044; req_wdata = 32'h11111111; req_wstrb = 4'b1111;
      req_valid = 1'b1; resp_ready = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      reset = 1'b1;
      #1;
      tests_run++;
      if (resp_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_valid got %0b want 0", resp_valid); end
      tests_run++;
      if (ram_write_en !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_we got %0b want 0", ram_write_en); end
      tests_run++;
      if (req_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_ready got %0b want 0", req_ready); end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      tests_run++;
      if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_ready_after got %0b want 1", req_ready); end
      tests_run++;
      if (wr_count !== w0) begin tests_failed++; $display("FAIL rst_mid_writes got %0d want %0d", wr_count, w0); end
      do_req(1'b0, 10'h044, 32'h0, 4'b0000, rd, acc, lat);
      tests_run++;
      if (rd !== 32'hCAFEF00D) begin tests_failed++; $display("FAIL rst_mid_word got %h want cafef00d", rd); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd;
      int acc1, acc2, lat;
      do_req(1'b1, 10'h080, 32'h12345678, 4'b1111, rd, acc1, lat);
      do_req(1'b0, 10'h080, 32'h0, 4'b0000, rd, acc2, lat);
      tests_run++;
      if (rd !== 32'h12345678) begin tests_failed++; $display("FAIL b2b_data got %h want 12345678", rd); end
      tests_run++;
      if (acc2 - acc1 !== 3) begin tests_failed++; $display("FAIL b2b_spacing got %0d want 3", acc2 - acc1); end
   endtask

   initial begin
      test_reset();
      test_full_write_read();
      test_partial_write();
      test_resp_stall();
      test_zero_strobe();
      test_reset_mid_op();
      test_back_to_back();
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got time %0t want completion", $time);
      $fatal(1, "timeout");
   end

endmodule
